fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/flopenrc.sv | 24 ++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults: word type, counter width, reset PC and bubble instruction.
// No logic, no latency; used by every pipeline stage.
package pipeline_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam word_t PKG_RESET_PC  = 32'h0000_0000;
   localparam word_t PKG_NOP_INSTR = 32'h0000_0000;
   localparam cnt_t  CNT_MAX       = {CNT_W{1'b1}};

   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == CNT_MAX) ? c : c + cnt_t'(1);
   endfunction

   function automatic word_t word_align(input word_t a);
      return a & ~word_t'(3);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard controls, redirect targets, imem data in; PC, Decode latch and counters out.
// master = surrounding pipeline/hazard unit, slave = fetch_stage.
interface fetch_stage_if;
   import pipeline_pkg::*;

   logic  StallF;
   logic  StallD;
   logic  FlushD;
   logic  BranchTakenE;
   word_t ALUResultE;
   logic  PCSrcW;
   word_t ResultW;
   word_t InstrF;
   word_t PCF;
   word_t InstrD;
   word_t PCPlus8D;
   logic  ValidD;
   cnt_t  StallCnt;
   cnt_t  FlushCnt;

   modport master (
      output StallF, StallD, FlushD, BranchTakenE, ALUResultE, PCSrcW, ResultW, InstrF,
      input  PCF, InstrD, PCPlus8D, ValidD, StallCnt, FlushCnt
   );

   modport slave (
      input  StallF, StallD, FlushD, BranchTakenE, ALUResultE, PCSrcW, ResultW, InstrF,
      output PCF, InstrD, PCPlus8D, ValidD, StallCnt, FlushCnt
   );

endinterface

// File: rtl/flopenrc.sv
// Enabled register with synchronous clear and async active-low reset; both load CLR_VAL.
// Latency 1 cycle; clr overrides en, en=0 holds.
module flopenrc #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= CLR_VAL;
      else if (clr)
         q <= CLR_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register with branch/writeback redirect, Fetch/Decode latch, stall/flush counters.
// Latency 1 cycle Fetch->Decode; StallF holds PC unless redirected, StallD holds Decode, FlushD bubbles it.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter word_t RESET_PC  = PKG_RESET_PC,
   parameter word_t NOP_INSTR = PKG_NOP_INSTR
) (
   input logic        clk,
   input logic        rst_n,
   fetch_stage_if.slave bus
);

   word_t pc_q;
   word_t pc_next;
   word_t pc_plus4;
   word_t pc_plus8;
   logic  redirect;
   logic  pc_en;
   cnt_t  stall_cnt_q;
   cnt_t  flush_cnt_q;

   assign pc_plus4 = pc_q + word_t'(4);
   assign pc_plus8 = pc_q + word_t'(8);
   assign redirect = bus.BranchTakenE | bus.PCSrcW;
   // A redirect must land even while the hazard unit is stalling fetch.
   assign pc_en    = redirect | ~bus.StallF;

   always_comb begin
      pc_next = pc_plus4;
      if (bus.BranchTakenE)
         pc_next = word_align(bus.ALUResultE);
      else if (bus.PCSrcW)
         pc_next = word_align(bus.ResultW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= RESET_PC;
      else if (pc_en)
         pc_q <= pc_next;
   end

   assign bus.PCF = pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (bus.StallF)
            stall_cnt_q <= sat_inc(stall_cnt_q);
         if (bus.FlushD)
            flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign bus.StallCnt = stall_cnt_q;
   assign bus.FlushCnt = flush_cnt_q;

   flopenrc #(.WIDTH(WORD_W), .CLR_VAL(NOP_INSTR)) u_instr_d (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~bus.StallD),
      .clr   (bus.FlushD),
      .d     (bus.InstrF),
      .q     (bus.InstrD)
   );

   flopenrc #(.WIDTH(WORD_W), .CLR_VAL('0)) u_pcplus8_d (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~bus.StallD),
      .clr   (bus.FlushD),
      .d     (pc_plus8),
      .q     (bus.PCPlus8D)
   );

   flopenrc #(.WIDTH(1), .CLR_VAL(1'b0)) u_valid_d (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~bus.StallD),
      .clr   (bus.FlushD),
      .d     (1'b1),
      .q     (bus.ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns PCF^IMEM_KEY so every fetch is traceable.
module tb_fetch_stage;
   import pipeline_pkg::*;

   localparam word_t NOP      = 32'hE1A0_0000;
   localparam word_t IMEM_KEY = 32'hE000_0000;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   assign bus.InstrF = bus.PCF ^ IMEM_KEY;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.StallF       = 1'b0;
      bus.StallD       = 1'b0;
      bus.FlushD       = 1'b0;
      bus.BranchTakenE = 1'b0;
      bus.ALUResultE   = '0;
      bus.PCSrcW       = 1'b0;
      bus.ResultW      = '0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".pcf"},   bus.PCF,      32'h0);
      check({tag, ".instr"}, bus.InstrD,   NOP);
      check({tag, ".pc8"},   bus.PCPlus8D, 32'h0);
      check({tag, ".valid"}, {31'd0, bus.ValidD}, 32'd0);
      check({tag, ".scnt"},  {16'd0, bus.StallCnt}, 32'd0);
      check({tag, ".fcnt"},  {16'd0, bus.FlushCnt}, 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      rst_n = 1'b0;
      #12;
      check_reset("reset");
      check("reset.instrf", bus.InstrF, IMEM_KEY);
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running: PCF 4,8,12,16 with PCPlus8D trailing by one cycle.
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("free%0d.pcf", i), bus.PCF, 32'(4 * i));
         check($sformatf("free%0d.pc8", i), bus.PCPlus8D, 32'(4 * i + 4));
         check($sformatf("free%0d.instr", i), bus.InstrD, IMEM_KEY ^ 32'(4 * i - 4));
         check($sformatf("free%0d.valid", i), {31'd0, bus.ValidD}, 32'd1);
      end

      // Two-cycle full stall at PCF=0x10.
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         check($sformatf("stall%0d.pcf", i), bus.PCF, 32'h10);
         check($sformatf("stall%0d.instr", i), bus.InstrD, IMEM_KEY ^ 32'h0C);
         check($sformatf("stall%0d.scnt", i), {16'd0, bus.StallCnt}, 32'(i));
      end
      idle();
      tick();
      check("resume.pcf", bus.PCF, 32'h14);
      check("resume.instr", bus.InstrD, IMEM_KEY ^ 32'h10);
      check("resume.pc8", bus.PCPlus8D, 32'h18);

      // Branch redirect beats StallF; flush beats load; target low bits cleared.
      bus.BranchTakenE = 1'b1;
      bus.ALUResultE   = 32'h103;
      bus.StallF       = 1'b1;
      bus.FlushD       = 1'b1;
      tick();
      check("br.pcf", bus.PCF, 32'h100);
      check("br.valid", {31'd0, bus.ValidD}, 32'd0);
      check("br.instr", bus.InstrD, NOP);
      check("br.pc8", bus.PCPlus8D, 32'h0);
      check("br.fcnt", {16'd0, bus.FlushCnt}, 32'd1);
      check("br.scnt", {16'd0, bus.StallCnt}, 32'd3);
      idle();
      tick();
      check("postbr.pcf", bus.PCF, 32'h104);
      check("postbr.instr", bus.InstrD, IMEM_KEY ^ 32'h100);
      check("postbr.valid", {31'd0, bus.ValidD}, 32'd1);

      // Branch has priority over writeback PC write.
      bus.BranchTakenE = 1'b1;
      bus.ALUResultE   = 32'h200;
      bus.PCSrcW       = 1'b1;
      bus.ResultW      = 32'h300;
      tick();
      check("prio.pcf", bus.PCF, 32'h200);
      check("prio.pc8", bus.PCPlus8D, 32'h10C);
      idle();
      bus.PCSrcW  = 1'b1;
      bus.ResultW = 32'h3FF;
      bus.StallF  = 1'b1;
      tick();
      check("wb.pcf", bus.PCF, 32'h3FC);

      // Wrap of PC+4 and PC+8 at the top of the address space.
      idle();
      bus.BranchTakenE = 1'b1;
      bus.ALUResultE   = 32'hFFFF_FFFF;
      tick();
      check("wrap0.pcf", bus.PCF, 32'hFFFF_FFFC);
      idle();
      tick();
      check("wrap1.pcf", bus.PCF, 32'h0);
      check("wrap1.pc8", bus.PCPlus8D, 32'h4);
      check("wrap1.instr", bus.InstrD, IMEM_KEY ^ 32'hFFFF_FFFC);

      // StallF alone: PC held, Decode refetches the same address.
      bus.StallF = 1'b1;
      tick();
      check("dup.pcf", bus.PCF, 32'h0);
      check("dup.instr", bus.InstrD, IMEM_KEY);
      check("dup.pc8", bus.PCPlus8D, 32'h8);
      check("dup.scnt", {16'd0, bus.StallCnt}, 32'd5);

      // StallD alone: Decode holds while PC advances.
      bus.StallF = 1'b0;
      bus.StallD = 1'b1;
      tick();
      check("sd.pcf", bus.PCF, 32'h4);
      check("sd.pc8", bus.PCPlus8D, 32'h8);

      // Long stall saturates the counter; reset mid-stall with a redirect pending.
      idle();
      bus.StallF = 1'b1;
      for (int i = 0; i < 70000; i++) @(posedge clk);
      #1;
      check("sat.scnt", {16'd0, bus.StallCnt}, 32'h0000_FFFF);
      check("sat.pcf", bus.PCF, 32'h4);
      check("sat.fcnt", {16'd0, bus.FlushCnt}, 32'd1);
      bus.BranchTakenE = 1'b1;
      bus.ALUResultE   = 32'h500;
      bus.FlushD       = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("arst");
      tick();
      check_reset("arst_hold");
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst.pcf", bus.PCF, 32'h4);
      check("post_rst.instr", bus.InstrD, IMEM_KEY);
      check("post_rst.pc8", bus.PCPlus8D, 32'h8);
      check("post_rst.valid", {31'd0, bus.ValidD}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
